dmem_port: RTL
==============

Name: dmem_port

Overview:
- Per-core data-memory access controller between the core datapath and the shared data-memory bus.
- Datapath side: consumes the datapath's data-memory address (DMADDR) and write data (DOUT); returns read data on DIN, which feeds the datapath's BIN mux during MEMREAD.
- Bus side: runs a request/grant/acknowledge handshake with the shared memory arbiter.
- Control-unit side: exposes BUSY/DONE so the control unit stalls until the access completes; a watchdog flags hung transfers.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, max cycles in REQ+XFER before abort (1..2^CW-1).
- CW, 8, timeout counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- MEMRD_REQ  input  1  read request pulse from control unit.
- MEMWR_REQ  input  1  write request pulse from control unit.
- DMADDR  input  AW  access address from datapath AR.
- DOUT  input  DW  write data from datapath DR.
- DIN  output  DW  read data to datapath.
- BUSY  output  1  access in progress; control unit must stall.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  sticky timeout flag.
- BUS_REQ  output  1  bus request to arbiter.
- BUS_GNT  input  1  arbiter grant.
- BUS_WE  output  1  1 = write, 0 = read.
- BUS_ADDR  output  AW  latched address.
- BUS_WDATA  output  DW  latched write data.
- BUS_RDATA  input  DW  memory read data.
- BUS_ACK  input  1  memory completion strobe.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE.
  - DIN, BUS_ADDR, BUS_WDATA = 0.
  - BUS_REQ, BUS_WE, BUSY, DONE, ERR = 0.
  - Counter = 0.
  - Reset mid-transfer aborts immediately; no DONE is issued.
- States are IDLE, REQ, XFER and FIN. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- IDLE:
  - On MEMWR_REQ or MEMRD_REQ, latch DMADDR into BUS_ADDR, DOUT into BUS_WDATA, and set BUS_WE (1 for write); clear ERR and the counter; go to REQ.
  - If both requests are high, the write wins and the read is dropped.
- REQ:
  - BUS_REQ=1 and the counter increments.
  - If BUS_GNT, go to XFER.
  - BUS_ACK is ignored in REQ.
- XFER:
  - BUS_REQ stays 1 and the counter increments.
  - On BUS_ACK: if it is a read, capture BUS_RDATA into DIN; go to FIN.
- Timeout:
  - In REQ or XFER, when the counter reaches TIMEOUT without the exit condition, set ERR=1 and go to FIN.
  - DIN is unchanged; no bus data is captured.
- FIN: DONE=1 for exactly one cycle, BUS_REQ=0, then go to IDLE unconditionally.
- BUSY = (state != IDLE).
- Requests arriving while BUSY=1 are ignored, not queued.
- Latency: request sampled at edge k, with GNT at k+1 and ACK at k+2, gives DONE high in cycle k+3. Minimum cycles from request to the next accepted request = 4.
- DIN holds its value until the next successful read. Writes and timeouts never modify DIN.
- BUS_ADDR, BUS_WDATA and BUS_WE stay stable from REQ through FIN; changes on DMADDR/DOUT after acceptance have no effect.
- ERR stays set across later idle cycles and clears only when the next request is accepted.
- BUS_GNT deasserting during XFER is ignored; the transfer completes on ACK.

Test Plan:
- Read: DMADDR=0x0040, MEMRD_REQ pulse; GNT at +1, ACK at +2 with BUS_RDATA=0xBEEF -> BUS_REQ high 2 cycles, BUS_WE=0, DONE at +3, DIN=0xBEEF, BUSY back to 0 at +4.
- Write: DMADDR=0x0012, DOUT=0x1234, MEMWR_REQ; GNT delayed 5 cycles, ACK 2 cycles later -> BUS_ADDR=0x0012, BUS_WDATA=0x1234, BUS_WE=1 throughout; DIN unchanged (0xBEEF); one DONE pulse.
- Simultaneous MEMRD_REQ and MEMWR_REQ -> write performed (BUS_WE=1); no read occurs afterwards.
- Timeout: TIMEOUT=10, never grant -> ERR=1 and DONE after 10 REQ cycles; DIN unchanged; next request clears ERR.
- Request while busy: second MEMRD_REQ at +1 with DMADDR=0x0099 -> ignored; BUS_ADDR keeps first address; exactly one DONE.
- Reset mid-XFER: drop rstn while waiting for ACK -> BUS_REQ, BUSY, DONE, DIN = 0 immediately; after release, state is IDLE and a fresh read completes normally.

Source files
------------

// File: rtl/dmem_port_if.sv
// Shared data-memory bus between a core's dmem_port (master) and the arbiter/memory (slave).
// Request is held until grant; the transfer completes on the memory's ACK strobe.
interface dmem_port_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          BUS_REQ;
    logic          BUS_GNT;
    logic          BUS_WE;
    logic [AW-1:0] BUS_ADDR;
    logic [DW-1:0] BUS_WDATA;
    logic [DW-1:0] BUS_RDATA;
    logic          BUS_ACK;

    modport master (
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
        input  BUS_GNT, BUS_RDATA, BUS_ACK
    );

    modport slave (
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
        output BUS_GNT, BUS_RDATA, BUS_ACK
    );
endinterface

// File: rtl/dmem_port.sv
// Per-core data-memory access controller: latches one request, runs REQ/GNT/ACK, pulses DONE (3 cycles best case).
// Requests arriving while BUSY are dropped, not queued; a watchdog aborts hung transfers with a sticky ERR.
module dmem_port #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          MEMRD_REQ,
    input  logic          MEMWR_REQ,
    input  logic [AW-1:0] DMADDR,
    input  logic [DW-1:0] DOUT,
    output logic [DW-1:0] DIN,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    dmem_port_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          timeout_hit;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] din_q;
    logic          we_q;
    logic          req_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    // Counter counts cycles spent in REQ+XFER; it fires when the next count would reach TIMEOUT.
    assign cnt_d       = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    assign timeout_hit = (cnt_d == TO_VAL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write takes priority; a simultaneous read is simply dropped.
                    if (MEMWR_REQ || MEMRD_REQ) begin
                        addr_q  <= DMADDR;
                        wdata_q <= DOUT;
                        we_q    <= MEMWR_REQ;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (bus.BUS_GNT) begin
                        state_q <= XFER;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                XFER: begin
                    cnt_q <= cnt_d;
                    if (bus.BUS_ACK) begin
                        if (!we_q) begin
                            din_q <= bus.BUS_RDATA;
                        end
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DIN           = din_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign bus.BUS_REQ   = req_q;
    assign bus.BUS_WE    = we_q;
    assign bus.BUS_ADDR  = addr_q;
    assign bus.BUS_WDATA = wdata_q;

endmodule
